// File: rtl/uart_rx_pkg.sv
// Shared defaults and window arithmetic for the UART RX oversampling bit sampler.
package uart_rx_pkg;

    localparam int DEF_MAX_PRESCALE = 32;
    localparam int DEF_NUM_SAMPLES  = 3;

    function automatic int prsc_width(input int max_prescale);
        return $clog2(max_prescale) + 1;
    endfunction

    // Window needs at least one idle count either side plus the wrap slot; keep it even.
    function automatic int min_prescale(input int num_samples);
        return ((num_samples + 3 + 1) / 2) * 2;
    endfunction

    function automatic int win_start(input int p, input int num_samples);
        return (p / 2) - ((num_samples - 1) / 2);
    endfunction

    function automatic int win_end(input int p, input int num_samples);
        return (p / 2) + ((num_samples - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_rx_edge_counter.sv
// Bit-period position counter: cleared while disabled or on resync, wraps at P-1.
module uart_rx_edge_counter
    import uart_rx_pkg::*;
#(
    parameter int PRSC_WIDTH = prsc_width(DEF_MAX_PRESCALE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  resync,
    input  logic [PRSC_WIDTH-1:0] p_eff,
    output logic [PRSC_WIDTH-1:0] edge_cnt
);

    logic [PRSC_WIDTH-1:0] p_last;

    assign p_last = p_eff - PRSC_WIDTH'(1);

    // >= rather than == so a shrunken ratio cannot strand the counter above its wrap point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (!enable || resync) begin
            edge_cnt <= '0;
        end else if (edge_cnt >= p_last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + PRSC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART RX bit sampler: majority vote over NUM_SAMPLES mid-bit samples with noise flag.
// Define UART_RX_SYNC_EN to insert a 2-flop input synchroniser ahead of sampling.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int MAX_PRESCALE = DEF_MAX_PRESCALE,
    parameter int PRSC_WIDTH   = prsc_width(MAX_PRESCALE),
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  resync,
    input  logic                  serial_data,
    input  logic [PRSC_WIDTH-1:0] prescale,
    output logic [PRSC_WIDTH-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  config_err
);

    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 7 || (NUM_SAMPLES % 2) == 0) begin : g_bad_samples
        $error("NUM_SAMPLES must be odd and in 1..7");
    end

    localparam logic [PRSC_WIDTH-1:0] P_MIN = PRSC_WIDTH'(min_prescale(NUM_SAMPLES));

    function automatic int ones_of(input logic [NUM_SAMPLES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic vote_bit(input logic [NUM_SAMPLES-1:0] v);
        return ones_of(v) > (NUM_SAMPLES / 2);
    endfunction

    function automatic logic vote_noise(input logic [NUM_SAMPLES-1:0] v);
        return (ones_of(v) != 0) && (ones_of(v) != NUM_SAMPLES);
    endfunction

    logic                   rx_s;
    logic [PRSC_WIDTH-1:0]  p_eff;
    logic [PRSC_WIDTH-1:0]  win_lo;
    logic [PRSC_WIDTH-1:0]  win_hi;
    logic                   in_window;
    logic                   last_sample;
    logic                   strobe_next;
    logic [NUM_SAMPLES-1:0] samples;
    logic [NUM_SAMPLES-1:0] samples_next;
    logic                   unused_prescale_lsb;

`ifdef UART_RX_SYNC_EN
    logic rx_p0;
    logic rx_p1;

    // Stage p0/p1: metastability synchroniser, idles high like the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= serial_data;
            rx_p1 <= rx_p0;
        end
    end
    assign rx_s = rx_p1;
`else
    assign rx_s = serial_data;
`endif

    assign unused_prescale_lsb = prescale[0];
    assign p_eff = {prescale[PRSC_WIDTH-1:1], 1'b0};
    assign win_lo = PRSC_WIDTH'(win_start(int'(p_eff), NUM_SAMPLES));
    assign win_hi = PRSC_WIDTH'(win_end(int'(p_eff), NUM_SAMPLES));

    uart_rx_edge_counter #(
        .PRSC_WIDTH(PRSC_WIDTH)
    ) u_edge_counter (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .resync  (resync),
        .p_eff   (p_eff),
        .edge_cnt(edge_cnt)
    );

    assign in_window   = (edge_cnt >= win_lo) && (edge_cnt <= win_hi);
    assign last_sample = (edge_cnt == win_hi);
    // Truncation keeps the low NUM_SAMPLES bits, i.e. shift in at the LSB.
    assign samples_next = NUM_SAMPLES'({samples, rx_s});
    assign strobe_next  = enable && !resync && !config_err && last_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples <= '0;
        end else if (!enable || resync || edge_cnt == '0) begin
            samples <= '0;
        end else if (in_window) begin
            samples <= samples_next;
        end
    end

    // Vote uses the bit being captured this edge, so the strobe lands one cycle after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_valid <= 1'b0;
            sampled_bit  <= 1'b0;
            noise_err    <= 1'b0;
            config_err   <= 1'b0;
        end else begin
            config_err   <= enable && (p_eff < P_MIN);
            sample_valid <= strobe_next;
            if (strobe_next) begin
                sampled_bit <= vote_bit(samples_next);
                noise_err   <= vote_noise(samples_next);
            end
        end
    end

endmodule
